// File: rtl/light_mode_decoder.sv
// Bike-light mode decoder: accepts a 2-bit mode code over valid/ready and applies it at PWM frame boundaries.
// Optional BLINK_RESTART_EN: restart the blink generator (phase on) when a boundary switches into blink.
module light_mode_decoder #(
  parameter int unsigned BLINK_HALF = 25000000,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned DIM_DUTY   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [3:0] mode,
  output logic       light
);

  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
  localparam logic [PWM_BITS:0]   DUTY       = (PWM_BITS+1)'(DIM_DUTY);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [3:0] MODE_OFF   = 4'b0001;
  localparam logic [3:0] MODE_ON    = 4'b0010;
  localparam logic [3:0] MODE_BLINK = 4'b0100;
  localparam logic [3:0] MODE_DIM   = 4'b1000;

  localparam logic [1:0] CODE_BLINK = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          pend_code, pend_nxt;
  logic [3:0]          mode_nxt;
  logic                ready_nxt;
  logic                light_nxt;
  logic                apply;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                boundary;
  logic [BW-1:0]       blink_cnt;
  logic                phase;
  logic                blink_wrap;
  logic                blink_restart;

  // Mode is only ever written from this decode, so it is always one-hot.
  function automatic logic [3:0] decode(input logic [1:0] c);
    case (c)
      2'b00:   decode = MODE_OFF;
      2'b01:   decode = MODE_ON;
      2'b10:   decode = MODE_BLINK;
      default: decode = MODE_DIM;
    endcase
  endfunction

  assign boundary   = (pwm_cnt == PWM_MAX);
  assign blink_wrap = (blink_cnt == BLINK_LAST);

`ifdef BLINK_RESTART_EN
  assign blink_restart = apply && (pend_code == CODE_BLINK) && (mode != MODE_BLINK);
`else
  assign blink_restart = 1'b0;
`endif

  // Handshake/apply state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pend_code  <= 2'b00;
      mode       <= MODE_OFF;
      code_ready <= 1'b1;
      light      <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_code  <= pend_nxt;
      mode       <= mode_nxt;
      code_ready <= ready_nxt;
      light      <= light_nxt;
    end
  end

  // Next-state: capture on handshake, apply on frame boundary
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_code;
    mode_nxt  = mode;
    apply     = 1'b0;
    light_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (code_valid && code_ready) begin
          pend_nxt  = code;
          state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (boundary) begin
          mode_nxt  = decode(pend_code);
          apply     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    ready_nxt = (state_nxt == S_IDLE);

    case (mode)
      MODE_ON:    light_nxt = 1'b1;
      MODE_BLINK: light_nxt = phase;
      MODE_DIM:   light_nxt = ({1'b0, pwm_cnt} < DUTY);
      default:    light_nxt = 1'b0;
    endcase
  end

  // Free-running PWM frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Blink half-period generator; runs regardless of mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_restart) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_light_mode_decoder.sv
// Directed self-checking bench for light_mode_decoder (PWM_BITS=4, DIM_DUTY=4, BLINK_HALF=8).
module tb_light_mode_decoder;

  logic       clk;
  logic       rst_n;
  logic [1:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [3:0] mode;
  logic       light;

  int         n_chk;
  int         n_pass;

  // Reference counters advanced once per edge, mirroring reset behaviour
  logic [3:0] m_pwm;
  int         m_bcnt;
  logic       m_phase;

  light_mode_decoder #(
    .BLINK_HALF(8),
    .PWM_BITS  (4),
    .DIM_DUTY  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code      (code),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .mode      (mode),
    .light     (light)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    if (!rst_n) begin
      m_pwm   = 4'd0;
      m_bcnt  = 0;
      m_phase = 1'b1;
    end else begin
      m_pwm = m_pwm + 4'd1;
      if (m_bcnt == 7) begin
        m_bcnt  = 0;
        m_phase = ~m_phase;
      end else begin
        m_bcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    code       = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic wait_mode(input string tag, input logic [3:0] exp, input int budget);
    int n;
    n = 0;
    while (mode !== exp && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(mode), 32'(exp));
  endtask

  initial begin
    logic [15:0] obs;
    logic [15:0] obs2;
    logic [15:0] expb;
    int          changes;

    n_chk      = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    code       = 2'b00;
    code_valid = 1'b0;
    m_pwm      = 4'd0;
    m_bcnt     = 0;
    m_phase    = 1'b1;

    // Reset held for three edges
    repeat (3) tick();
    chk("rst_mode", 32'(mode), 32'h1);
    chk("rst_light", 32'(light), 32'h0);
    chk("rst_ready", 32'(code_ready), 32'h1);
    rst_n = 1'b1;

    // First boundary passes with no pending code
    repeat (15) tick();
    chk("first_bnd_pre", 32'(mode), 32'h1);
    tick();
    chk("first_bnd_mode", 32'(mode), 32'h1);
    chk("first_bnd_ready", 32'(code_ready), 32'h1);

    // Accept at pwm_cnt=5 -> applied 10 edges later
    while (m_pwm != 4'd5) tick();
    send(2'b01);
    chk("hs_ready_low", 32'(code_ready), 32'h0);
    repeat (9) tick();
    chk("hs_mode_hold", 32'(mode), 32'h1);
    tick();
    chk("hs_mode_on", 32'(mode), 32'h2);
    chk("hs_ready_back", 32'(code_ready), 32'h1);
    chk("hs_light_lag", 32'(light), 32'h0);
    tick();
    chk("hs_light_on", 32'(light), 32'h1);

    // Accept at pwm_cnt=15 -> full-frame wait, then dim 4/16
    while (m_pwm != 4'd15) tick();
    send(2'b11);
    repeat (15) tick();
    chk("bnd_mode_hold", 32'(mode), 32'h2);
    tick();
    chk("bnd_mode_dim", 32'(mode), 32'h8);
    for (int i = 0; i < 16; i++) begin
      tick();
      obs[i] = light;
    end
    chk("dim_pattern", 32'(obs), 32'h000F);

    // Back-pressure: 10 then 00 held valid; 00 only after ready returns
    code       = 2'b10;
    code_valid = 1'b1;
    tick();
    code = 2'b00;
    chk("bp_ready_low", 32'(code_ready), 32'h0);
    wait_mode("bp_mode_blink", 4'h4, 20);
    chk("bp_ready_back", 32'(code_ready), 32'h1);
    tick();
    code_valid = 1'b0;
    chk("bp_second_accept", 32'(code_ready), 32'h0);
    repeat (14) tick();
    chk("bp_mode_hold", 32'(mode), 32'h4);
    tick();
    chk("bp_mode_off", 32'(mode), 32'h1);

    // on -> blink, light follows the blink phase
    send(2'b01);
    wait_mode("blk_mode_on", 4'h2, 20);
    send(2'b10);
    wait_mode("blk_mode_blink", 4'h4, 20);
`ifdef BLINK_RESTART_EN
    m_bcnt  = 0;
    m_phase = 1'b1;
`endif
    for (int i = 0; i < 16; i++) begin
      expb[i] = m_phase;
      tick();
      obs[i] = light;
    end
    chk("blink_phase", 32'(obs), 32'(expb));
`ifdef BLINK_RESTART_EN
    chk("blink_restart", 32'(obs), 32'h00FF);
`endif
    for (int i = 0; i < 16; i++) begin
      tick();
      obs2[i] = light;
    end
    chk("blink_period", 32'(obs2), 32'(obs));

    // Reset while a code is pending, with a simultaneous offer
    send(2'b11);
    chk("mrst_pending", 32'(code_ready), 32'h0);
    code       = 2'b10;
    code_valid = 1'b1;
    rst_n      = 1'b0;
    tick();
    rst_n      = 1'b1;
    code_valid = 1'b0;
    chk("mrst_mode", 32'(mode), 32'h1);
    chk("mrst_ready", 32'(code_ready), 32'h1);
    chk("mrst_light", 32'(light), 32'h0);
    changes = 0;
    repeat (40) begin
      tick();
      if (mode !== 4'h1) changes++;
    end
    chk("mrst_no_change", 32'(changes), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
